// File: rtl/risc_mgmt_exec_arbiter.sv
// risc_mgmt_exec_arbiter: execute-stage arbiter for RISC-MGMT extensions.
// Launches one of N_EXT extensions, stalls while it is busy, lends it the
// shared ALU, enforces a busy timeout and returns one registered result beat.
//
// Ports:
//   CLK, nRST              clock, asynchronous active-low reset
//   start, sel, flush      launch request, channel index, pipeline abort
//   rdata_s_0/1            source operands (broadcast to extensions)
//   ext_start              one-hot launch pulse per channel
//   ext_busy..ext_alu_op   per-channel status, data and ALU requests
//   ext_alu_res            shared ALU result back to extensions
//   alu_access/data/op     ALU request from the owning channel
//   alu_res                ALU result
//   stall                  hold the pipeline
//   done, reg_w, reg_wdata one-cycle result beat and write-back
//   branch_jump, br_j_addr redirect request
//   exception, exc_cause   0 none, 1 extension, 2 timeout, 3 illegal sel

module risc_mgmt_exec_arbiter #(
    parameter int N_EXT       = 4,
    parameter int DATA_W      = 32,
    parameter int ALUOP_W     = 4,
    parameter int TIMEOUT_CYC = 64,
    localparam int SEL_W      = (N_EXT > 1) ? $clog2(N_EXT) : 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      start,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         rdata_s_0,
    input  logic [DATA_W-1:0]         rdata_s_1,
    output logic [N_EXT-1:0]          ext_start,
    input  logic [N_EXT-1:0]          ext_busy,
    input  logic [N_EXT-1:0]          ext_exception,
    input  logic [N_EXT-1:0]          ext_reg_w,
    input  logic [N_EXT-1:0]          ext_branch_jump,
    input  logic [N_EXT-1:0]          ext_alu_access,
    input  logic [N_EXT*DATA_W-1:0]   ext_reg_wdata,
    input  logic [N_EXT*DATA_W-1:0]   ext_br_j_addr,
    input  logic [N_EXT*DATA_W-1:0]   ext_alu_data_0,
    input  logic [N_EXT*DATA_W-1:0]   ext_alu_data_1,
    input  logic [N_EXT*ALUOP_W-1:0]  ext_alu_op,
    output logic [DATA_W-1:0]         ext_alu_res,
    output logic                      alu_access,
    output logic [DATA_W-1:0]         alu_data_0,
    output logic [DATA_W-1:0]         alu_data_1,
    output logic [ALUOP_W-1:0]        alu_op,
    input  logic [DATA_W-1:0]         alu_res,
    output logic                      stall,
    output logic                      done,
    output logic                      reg_w,
    output logic [DATA_W-1:0]         reg_wdata,
    output logic                      branch_jump,
    output logic [DATA_W-1:0]         br_j_addr,
    output logic                      exception,
    output logic [1:0]                exc_cause
);

    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_EXT  = 2'd1;
    localparam logic [1:0] CAUSE_TMO  = 2'd2;
    localparam logic [1:0] CAUSE_SEL  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    own_q, own_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                reg_w_q, reg_w_d;
    logic                bj_q, bj_d;
    logic                exc_q, exc_d;
    logic [1:0]          cause_q, cause_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   addr_q, addr_d;

    // Signals of the owning channel
    logic                own_busy;
    logic                own_exc;
    logic                own_rw;
    logic                own_bj;
    logic                own_acc;
    logic [DATA_W-1:0]   own_wdata;
    logic [DATA_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_d0;
    logic [DATA_W-1:0]   own_d1;
    logic [ALUOP_W-1:0]  own_op;

    logic                accept;
    logic                sel_legal;
    logic                tmo_hit;
    logic                in_run;

    // Operands are broadcast straight to the extensions by the decode path;
    // the arbiter itself never looks at them.
    logic                unused_ok;
    assign unused_ok = ^{rdata_s_0, rdata_s_1};

    assign in_run    = (state_q == S_RUN);
    assign sel_legal = ({1'b0, sel} < (SEL_W + 1)'(N_EXT));
    assign accept    = start && !flush && !in_run;
    assign tmo_hit   = (TIMEOUT_CYC != 0) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYC));

    always_comb begin
        own_busy  = 1'b0;
        own_exc   = 1'b0;
        own_rw    = 1'b0;
        own_bj    = 1'b0;
        own_acc   = 1'b0;
        own_wdata = '0;
        own_addr  = '0;
        own_d0    = '0;
        own_d1    = '0;
        own_op    = '0;
        for (int i = 0; i < N_EXT; i++) begin
            if (own_q == SEL_W'(i)) begin
                own_busy  = ext_busy[i];
                own_exc   = ext_exception[i];
                own_rw    = ext_reg_w[i];
                own_bj    = ext_branch_jump[i];
                own_acc   = ext_alu_access[i];
                own_wdata = ext_reg_wdata[i*DATA_W +: DATA_W];
                own_addr  = ext_br_j_addr[i*DATA_W +: DATA_W];
                own_d0    = ext_alu_data_0[i*DATA_W +: DATA_W];
                own_d1    = ext_alu_data_1[i*DATA_W +: DATA_W];
                own_op    = ext_alu_op[i*ALUOP_W +: ALUOP_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        cnt_d     = cnt_q;
        reg_w_d   = 1'b0;
        bj_d      = 1'b0;
        exc_d     = 1'b0;
        cause_d   = CAUSE_NONE;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        ext_start = '0;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_RUN: begin
                    // A finishing extension beats a timeout in the same cycle
                    if (!own_busy) begin
                        state_d = S_DONE;
                        reg_w_d = own_rw & ~own_exc;
                        bj_d    = own_bj & ~own_exc;
                        exc_d   = own_exc;
                        cause_d = own_exc ? CAUSE_EXT : CAUSE_NONE;
                        wdata_d = own_wdata;
                        addr_d  = own_addr;
                    end else if (tmo_hit) begin
                        state_d = S_DONE;
                        exc_d   = 1'b1;
                        cause_d = CAUSE_TMO;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (accept) begin
                        if (sel_legal) begin
                            for (int i = 0; i < N_EXT; i++) begin
                                ext_start[i] = (sel == SEL_W'(i));
                            end
                            own_d   = sel;
                            cnt_d   = '0;
                            state_d = S_RUN;
                        end else begin
                            state_d = S_DONE;
                            exc_d   = 1'b1;
                            cause_d = CAUSE_SEL;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            own_q   <= '0;
            cnt_q   <= '0;
            reg_w_q <= 1'b0;
            bj_q    <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= CAUSE_NONE;
            wdata_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            reg_w_q <= reg_w_d;
            bj_q    <= bj_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
        end
    end

    assign stall       = in_run | accept;
    assign done        = (state_q == S_DONE);
    assign reg_w       = reg_w_q;
    assign reg_wdata   = wdata_q;
    assign branch_jump = bj_q;
    assign br_j_addr   = addr_q;
    assign exception   = exc_q;
    assign exc_cause   = cause_q;

    assign ext_alu_res = alu_res;
    assign alu_access  = in_run & own_acc;
    assign alu_data_0  = in_run ? own_d0 : '0;
    assign alu_data_1  = in_run ? own_d1 : '0;
    assign alu_op      = in_run ? own_op : '0;

endmodule

// File: tb/tb_risc_mgmt_exec_arbiter.sv
// tb_risc_mgmt_exec_arbiter: cycle table for the execute arbiter
// plus a hand-written asynchronous reset sequence.

module tb_risc_mgmt_exec_arbiter;

    localparam int N   = 3;
    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int TMO = 8;
    localparam logic [AW-1:0] OP_ADD = 4'h1;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      sel = '0;
    logic            flush = 1'b0;
    logic [DW-1:0]   rdata_s_0 = 32'h0;
    logic [DW-1:0]   rdata_s_1 = 32'h0;
    logic [N-1:0]    ext_start;
    logic [N-1:0]    ext_busy = '0;
    logic [N-1:0]    ext_exception = '0;
    logic [N-1:0]    ext_reg_w;
    logic [N-1:0]    ext_branch_jump;
    logic [N-1:0]    ext_alu_access;
    logic [N*DW-1:0] ext_reg_wdata;
    logic [N*DW-1:0] ext_br_j_addr;
    logic [N*DW-1:0] ext_alu_data_0;
    logic [N*DW-1:0] ext_alu_data_1;
    logic [N*AW-1:0] ext_alu_op;
    logic [DW-1:0]   ext_alu_res;
    logic            alu_access;
    logic [DW-1:0]   alu_data_0;
    logic [DW-1:0]   alu_data_1;
    logic [AW-1:0]   alu_op;
    logic [DW-1:0]   alu_res;
    logic            stall;
    logic            done;
    logic            reg_w;
    logic [DW-1:0]   reg_wdata;
    logic            branch_jump;
    logic [DW-1:0]   br_j_addr;
    logic            exception;
    logic [1:0]      exc_cause;

    always #5 CLK = ~CLK;

    // Fixed channel personalities:
    //   ch0 branch to 0x100, ch1 writes 0x11111111 using ALU 3+4,
    //   ch2 writes 0xDEADBEEF without ALU.
    assign ext_reg_w       = 3'b110;
    assign ext_branch_jump = 3'b001;
    assign ext_alu_access  = 3'b010;
    assign ext_reg_wdata   = {32'hDEADBEEF, 32'h11111111, 32'h0};
    assign ext_br_j_addr   = {32'h0, 32'h0, 32'h100};
    assign ext_alu_data_0  = {32'h0, 32'd3, 32'h0};
    assign ext_alu_data_1  = {32'h0, 32'd4, 32'h0};
    assign ext_alu_op      = {4'h0, OP_ADD, 4'h0};

    // Bench ALU
    assign alu_res = (alu_op == OP_ADD) ? alu_data_0 + alu_data_1 : 32'h0;

    risc_mgmt_exec_arbiter #(
        .N_EXT(N), .DATA_W(DW), .ALUOP_W(AW), .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK(CLK), .nRST(nRST), .start(start), .sel(sel), .flush(flush),
        .rdata_s_0(rdata_s_0), .rdata_s_1(rdata_s_1),
        .ext_start(ext_start), .ext_busy(ext_busy),
        .ext_exception(ext_exception), .ext_reg_w(ext_reg_w),
        .ext_branch_jump(ext_branch_jump), .ext_alu_access(ext_alu_access),
        .ext_reg_wdata(ext_reg_wdata), .ext_br_j_addr(ext_br_j_addr),
        .ext_alu_data_0(ext_alu_data_0), .ext_alu_data_1(ext_alu_data_1),
        .ext_alu_op(ext_alu_op), .ext_alu_res(ext_alu_res),
        .alu_access(alu_access), .alu_data_0(alu_data_0),
        .alu_data_1(alu_data_1), .alu_op(alu_op), .alu_res(alu_res),
        .stall(stall), .done(done), .reg_w(reg_w), .reg_wdata(reg_wdata),
        .branch_jump(branch_jump), .br_j_addr(br_j_addr),
        .exception(exception), .exc_cause(exc_cause)
    );

    typedef struct {
        logic        st;
        logic [1:0]  sl;
        logic        fl;
        logic [2:0]  bz;
        logic [2:0]  exi;
        logic [2:0]  es;
        logic        stl;
        logic        dn;
        logic        rw;
        logic [31:0] wd;
        logic        bj;
        logic        ex;
        logic [1:0]  cs;
        logic        alu;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad = 0;

    function automatic vec_t row(
        input logic st, input logic [1:0] sl, input logic fl,
        input logic [2:0] bz, input logic [2:0] exi,
        input logic [2:0] es, input logic stl, input logic dn,
        input logic rw, input logic [31:0] wd, input logic bj,
        input logic ex, input logic [1:0] cs, input logic alu);
        vec_t v;
        v.st = st; v.sl = sl; v.fl = fl; v.bz = bz; v.exi = exi;
        v.es = es; v.stl = stl; v.dn = dn; v.rw = rw; v.wd = wd;
        v.bj = bj; v.ex = ex; v.cs = cs; v.alu = alu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        tbl.push_back(row(0,0,0,0,0, 0,0,0, 0,0,0,0,0,0));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " stall"}, 32'(stall), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " reg_w"}, 32'(reg_w), 0);
        chk({tag, " bj"}, 32'(branch_jump), 0);
        chk({tag, " exc"}, 32'(exception), 0);
        chk({tag, " cause"}, 32'(exc_cause), 0);
        chk({tag, " ext_start"}, 32'(ext_start), 0);
        chk({tag, " alu_acc"}, 32'(alu_access), 0);
        chk({tag, " alu_d0"}, alu_data_0, 0);
        chk({tag, " alu_d1"}, alu_data_1, 0);
        chk({tag, " wdata"}, reg_wdata, 0);
        chk({tag, " addr"}, br_j_addr, 0);
    endtask

    initial begin
        // sel=2 immediate completion
        tbl.push_back(row(1,2,0,3'b000,0, 3'b100,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,3'b000,0, 3'b000,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,3'b000,0, 3'b000,0,1,
                          1,32'hDEADBEEF,0,0,0,0));
        idle();
        // sel=1 busy five cycles using the ALU
        tbl.push_back(row(1,1,0,3'b010,0, 3'b010,1,0, 0,0,0,0,0,0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(row(0,0,0,3'b010,0, 0,1,0, 0,0,0,0,0,1));
        tbl.push_back(row(0,0,0,3'b000,0, 0,1,0, 0,0,0,0,0,1));
        tbl.push_back(row(0,0,0,3'b000,0, 0,0,1,
                          1,32'h11111111,0,0,0,0));
        idle();
        // busy stuck: timeout after TMO counted cycles
        tbl.push_back(row(1,2,0,3'b100,0, 3'b100,1,0, 0,0,0,0,0,0));
        for (int k = 0; k < 9; k++)
            tbl.push_back(row(0,0,0,3'b100,0, 0,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,3'b100,0, 0,0,1, 0,0,0,1,2,0));
        idle();
        // illegal sel
        tbl.push_back(row(1,3,0,0,0, 0,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,0,0, 0,0,1, 0,0,0,1,3,0));
        idle();
        // flush in third RUN cycle, then back-to-back sel=0
        tbl.push_back(row(1,1,0,3'b010,0, 3'b010,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,3'b010,0, 0,1,0, 0,0,0,0,0,1));
        tbl.push_back(row(0,0,0,3'b010,0, 0,1,0, 0,0,0,0,0,1));
        tbl.push_back(row(0,0,1,3'b010,0, 0,1,0, 0,0,0,0,0,1));
        tbl.push_back(row(1,0,0,0,0, 3'b001,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(1,0,0,0,0, 3'b000,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(1,0,0,0,0, 3'b001,1,1, 0,0,1,0,0,0));
        tbl.push_back(row(0,0,0,0,0, 0,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,0,0, 0,0,1, 0,0,1,0,0,0));
        tbl.push_back(row(1,2,1,0,0, 0,0,0, 0,0,0,0,0,0));
        idle();
        // extension exception masks write-back
        tbl.push_back(row(1,2,0,0,3'b100, 3'b100,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,0,3'b100, 0,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,0,3'b100, 0,0,1, 0,0,0,1,1,0));
        idle();
        // busy drops exactly when the counter hits the limit
        tbl.push_back(row(1,2,0,3'b100,0, 3'b100,1,0, 0,0,0,0,0,0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(row(0,0,0,3'b100,0, 0,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,3'b000,0, 0,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,3'b000,0, 0,0,1,
                          1,32'hDEADBEEF,0,0,0,0));
        idle();
        // flush during DONE kills a coincident start
        tbl.push_back(row(1,2,0,0,0, 3'b100,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(0,0,0,0,0, 0,1,0, 0,0,0,0,0,0));
        tbl.push_back(row(1,2,1,0,0, 0,0,1, 1,32'hDEADBEEF,0,0,0,0));
        idle();

        // Reset state
        #3;
        chk_quiet("reset");
        @(posedge CLK); #1;
        nRST = 1'b1;

        foreach (tbl[i]) begin
            @(posedge CLK); #1;
            start         = tbl[i].st;
            sel           = tbl[i].sl;
            flush         = tbl[i].fl;
            ext_busy      = tbl[i].bz;
            ext_exception = tbl[i].exi;
            @(negedge CLK);
            chk($sformatf("r%0d ext_start", i), 32'(ext_start),
                32'(tbl[i].es));
            chk($sformatf("r%0d stall", i), 32'(stall), 32'(tbl[i].stl));
            chk($sformatf("r%0d done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("r%0d reg_w", i), 32'(reg_w), 32'(tbl[i].rw));
            chk($sformatf("r%0d bj", i), 32'(branch_jump),
                32'(tbl[i].bj));
            chk($sformatf("r%0d exc", i), 32'(exception), 32'(tbl[i].ex));
            chk($sformatf("r%0d cause", i), 32'(exc_cause),
                32'(tbl[i].cs));
            chk($sformatf("r%0d alu_acc", i), 32'(alu_access),
                32'(tbl[i].alu));
            chk($sformatf("r%0d alu_d0", i), alu_data_0,
                tbl[i].alu ? 32'd3 : 32'd0);
            chk($sformatf("r%0d alu_d1", i), alu_data_1,
                tbl[i].alu ? 32'd4 : 32'd0);
            chk($sformatf("r%0d alu_op", i), 32'(alu_op),
                tbl[i].alu ? 32'(OP_ADD) : 32'd0);
            chk($sformatf("r%0d alu_res", i), ext_alu_res,
                tbl[i].alu ? 32'd7 : 32'd0);
            if (tbl[i].rw)
                chk($sformatf("r%0d wdata", i), reg_wdata, tbl[i].wd);
            if (tbl[i].bj)
                chk($sformatf("r%0d addr", i), br_j_addr, 32'h100);
        end

        // Asynchronous reset in the middle of a RUN
        @(posedge CLK); #1;
        start    = 1'b1;
        sel      = 2'd1;
        flush    = 1'b0;
        ext_busy = 3'b010;
        ext_exception = '0;
        @(posedge CLK); #1;
        start = 1'b0;
        @(negedge CLK);
        chk("pre-rst stall", 32'(stall), 1);
        chk("pre-rst alu_acc", 32'(alu_access), 1);
        #2;
        nRST = 1'b0;
        #1;
        chk_quiet("async-rst");
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        chk("post-rst stall", 32'(stall), 0);
        chk("post-rst alu_acc", 32'(alu_access), 0);
        @(negedge CLK);
        chk("post-rst done", 32'(done), 0);
        chk("post-rst stall2", 32'(stall), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
